reg_bank_rw: RTL

//   32 x 32-bit general-purpose register bank for the multicycle datapath.

---
 rtl/reg_bank_rw.sv | 100 ++++++++++
 1 files changed

// File: rtl/reg_bank_rw.sv
// 32-entry register bank with two combinational read ports, one synchronous
// write port and a pair of ALU operand latches loaded with write-through.
module reg_bank_rw #(
   parameter int DATA_W = 32,
   parameter int SP_IDX = 29,
   parameter int SP_RST = 227
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr_a,
   input  logic [4:0]        rd_addr_b,
   input  logic              ld_ab,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b
);

   logic [DATA_W-1:0] regs_r [0:31];
   logic [DATA_W-1:0] op_a_r;
   logic [DATA_W-1:0] op_b_r;
   logic [DATA_W-1:0] rd_a_s;
   logic [DATA_W-1:0] rd_b_s;
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;
   logic              wr_live_s;

   // Read ports: index 0 always reads zero; no bypass of a pending write.
   always_comb begin
      rd_a_s = {DATA_W{1'b0}};
      rd_b_s = {DATA_W{1'b0}};
      if (rd_addr_a == 5'd0) begin
         rd_a_s = {DATA_W{1'b0}};
      end else begin
         rd_a_s = regs_r[rd_addr_a];
      end
      if (rd_addr_b == 5'd0) begin
         rd_b_s = {DATA_W{1'b0}};
      end else begin
         rd_b_s = regs_r[rd_addr_b];
      end
   end

   // Latch sources: a same-edge write to the selected register wins over the array.
   always_comb begin
      wr_live_s = wr_en && (wr_addr != 5'd0);
      fwd_a_s   = rd_a_s;
      fwd_b_s   = rd_b_s;
      if (wr_live_s && (wr_addr == rd_addr_a)) begin
         fwd_a_s = wr_data;
      end else begin
         fwd_a_s = rd_a_s;
      end
      if (wr_live_s && (wr_addr == rd_addr_b)) begin
         fwd_b_s = wr_data;
      end else begin
         fwd_b_s = rd_b_s;
      end
   end

   // Register array: reset loads the stack pointer, otherwise takes the write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            if (i == SP_IDX) begin
               regs_r[i] <= DATA_W'(SP_RST);
            end else begin
               regs_r[i] <= {DATA_W{1'b0}};
            end
         end
      end else if (wr_live_s) begin
         regs_r[wr_addr] <= wr_data;
      end else begin
         regs_r[wr_addr] <= regs_r[wr_addr];
      end
   end

   // Operand latches hold between ld_ab pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_a_r <= {DATA_W{1'b0}};
         op_b_r <= {DATA_W{1'b0}};
      end else if (ld_ab) begin
         op_a_r <= fwd_a_s;
         op_b_r <= fwd_b_s;
      end else begin
         op_a_r <= op_a_r;
         op_b_r <= op_b_r;
      end
   end

   assign rd_a = rd_a_s;
   assign rd_b = rd_b_s;
   assign op_a = op_a_r;
   assign op_b = op_b_r;

endmodule
